// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path:
// state enum, datapath select codes and the control bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    BRANCHL  = 4'd10,
    ILLEGAL  = 4'd11
  } statetype_t;

  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_ALU     = 1'b1;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_BR     = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BR       = 2'b10;

  localparam logic [4:0] FN_NOP      = 5'b10010;
  localparam logic [4:0] FN_NONE     = 5'b00000;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] ressrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       brl;
    logic       aluop;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(statetype_t s);
    ctrl_t c;
    c = '0;
    unique case (s)
      FETCH: begin
        c.adrsrc  = ADR_PC;
        c.srca    = SRCA_PC;
        c.srcb    = SRCB_FOUR;
        c.ressrc  = RES_ALURES;
        c.irwrite = 1'b1;
        c.nextpc  = 1'b1;
      end
      DECODE: begin
        c.srca   = SRCA_PC;
        c.srcb   = SRCB_FOUR;
        c.ressrc = RES_ALURES;
      end
      MEMADR: begin
        c.srca = SRCA_REG;
        c.srcb = SRCB_IMM;
      end
      MEMRD: begin
        c.adrsrc = ADR_ALU;
        c.ressrc = RES_ALUOUT;
      end
      MEMWB: begin
        c.ressrc = RES_DATA;
        c.regw   = 1'b1;
      end
      MEMWR: begin
        c.adrsrc = ADR_ALU;
        c.ressrc = RES_ALUOUT;
        c.memw   = 1'b1;
      end
      EXECUTER: begin
        c.srca  = SRCA_REG;
        c.srcb  = SRCB_REG;
        c.aluop = 1'b1;
      end
      EXECUTEI: begin
        c.srca  = SRCA_REG;
        c.srcb  = SRCB_IMM;
        c.aluop = 1'b1;
      end
      ALUWB: begin
        c.ressrc = RES_ALUOUT;
        c.regw   = 1'b1;
      end
      BRANCH: begin
        c.srca   = SRCA_BR;
        c.srcb   = SRCB_IMM;
        c.ressrc = RES_ALURES;
        c.branch = 1'b1;
      end
      BRANCHL: begin
        c.srca   = SRCA_BR;
        c.srcb   = SRCB_IMM;
        c.ressrc = RES_ALURES;
        c.branch = 1'b1;
        c.brl    = 1'b1;
        c.regw   = 1'b1;
      end
      ILLEGAL: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle core:
// sequences fetch/decode/execute and drives datapath selects.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       BrL,
  output logic       ALUOp,
  output logic       Illegal
);

  statetype_t state;
  statetype_t state_n;
  ctrl_t      ctl;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = FETCH;
    unique case (state)
      FETCH:  state_n = DECODE;
      DECODE: begin
        unique case (Op)
          OP_MEM: state_n = MEMADR;
          OP_DP: begin
            // NOP wins over the immediate bit
            if (Funct[4:0] == FN_NOP)       state_n = FETCH;
            else if (Funct[5])              state_n = EXECUTEI;
            else if (Funct[4:0] == FN_NONE) state_n = FETCH;
            else                            state_n = EXECUTER;
          end
          OP_BR:   state_n = Funct[4] ? BRANCHL : BRANCH;
          default: state_n = ILLEGAL;
        endcase
      end
      MEMADR:   state_n = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWR:    state_n = FETCH;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BRANCH:   state_n = FETCH;
      BRANCHL:  state_n = FETCH;
      ILLEGAL:  state_n = FETCH;
      default:  state_n = FETCH;
    endcase
  end

  // reset masks every enable and select
  always_comb begin
    ctl = '0;
    if (!reset) ctl = state_ctrl(state);
  end

  assign IRWrite   = ctl.irwrite;
  assign NextPC    = ctl.nextpc;
  assign AdrSrc    = ctl.adrsrc;
  assign ALUSrcA   = ctl.srca;
  assign ALUSrcB   = ctl.srcb;
  assign ResultSrc = ctl.ressrc;
  assign RegW      = ctl.regw;
  assign MemW      = ctl.memw;
  assign Branch    = ctl.branch;
  assign BrL       = ctl.brl;
  assign ALUOp     = ctl.aluop;
  assign Illegal   = ctl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed vector bench for multicycle_ctrl_fsm:
// per-instruction output sequences plus reset corner cases.
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, NextPC, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       RegW, MemW, Branch, BrL, ALUOp, Illegal;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .BrL(BrL),
    .ALUOp(ALUOp), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] outs;
  assign outs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
                 ResultSrc, RegW, MemW, Branch, BrL, ALUOp, Illegal};

  // {IR,NPC,Adr,A[2],B[2],Res[2],RegW,MemW,Br,BrL,ALUOp,Ill}
  localparam logic [14:0] E_ZERO  = 15'b0;
  localparam logic [14:0] E_FETCH = {3'b110, 2'b01, 2'b10, 2'b10, 6'b000000};
  localparam logic [14:0] E_DEC   = {3'b000, 2'b01, 2'b10, 2'b10, 6'b000000};
  localparam logic [14:0] E_MADR  = {3'b000, 2'b00, 2'b01, 2'b00, 6'b000000};
  localparam logic [14:0] E_MRD   = {3'b001, 2'b00, 2'b00, 2'b00, 6'b000000};
  localparam logic [14:0] E_MWB   = {3'b000, 2'b00, 2'b00, 2'b01, 6'b100000};
  localparam logic [14:0] E_MWR   = {3'b001, 2'b00, 2'b00, 2'b00, 6'b010000};
  localparam logic [14:0] E_EXR   = {3'b000, 2'b00, 2'b00, 2'b00, 6'b000010};
  localparam logic [14:0] E_EXI   = {3'b000, 2'b00, 2'b01, 2'b00, 6'b000010};
  localparam logic [14:0] E_AWB   = {3'b000, 2'b00, 2'b00, 2'b00, 6'b100000};
  localparam logic [14:0] E_BR    = {3'b000, 2'b10, 2'b01, 2'b10, 6'b001000};
  localparam logic [14:0] E_BRL   = {3'b000, 2'b10, 2'b01, 2'b10, 6'b101100};
  localparam logic [14:0] E_ILL   = {3'b000, 2'b00, 2'b00, 2'b00, 6'b000001};

  typedef struct {
    string             name;
    logic [1:0]        op;
    logic [5:0]        funct;
    int                len;
    logic [4:0][14:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_fail;
  logic mon;
  logic saw_wr;

  always @(negedge clk)
    if (mon && (RegW || MemW)) saw_wr = 1'b1;

  task automatic add(input string nm, input logic [1:0] op,
                     input logic [5:0] fn, input int len,
                     input logic [14:0] e0, input logic [14:0] e1,
                     input logic [14:0] e2, input logic [14:0] e3,
                     input logic [14:0] e4);
    vec_t v;
    v.name  = nm;
    v.op    = op;
    v.funct = fn;
    v.len   = len;
    v.exp   = {e4, e3, e2, e1, e0};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [14:0] act,
                     input logic [14:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mon    = 1'b0;
    saw_wr = 1'b0;
    reset  = 1'b1;
    Op     = 2'b00;
    Funct  = 6'b0;

    add("LDR",   2'b01, 6'b011001, 5, E_FETCH, E_DEC, E_MADR, E_MRD, E_MWB);
    add("STR",   2'b01, 6'b011000, 4, E_FETCH, E_DEC, E_MADR, E_MWR, E_ZERO);
    add("ADDI",  2'b00, 6'b101000, 4, E_FETCH, E_DEC, E_EXI, E_AWB, E_ZERO);
    add("ADDR",  2'b00, 6'b001000, 4, E_FETCH, E_DEC, E_EXR, E_AWB, E_ZERO);
    add("BL",    2'b10, 6'b010000, 3, E_FETCH, E_DEC, E_BRL, E_ZERO, E_ZERO);
    add("B",     2'b10, 6'b000000, 3, E_FETCH, E_DEC, E_BR, E_ZERO, E_ZERO);
    add("NOP",   2'b00, 6'b010010, 2, E_FETCH, E_DEC, E_ZERO, E_ZERO, E_ZERO);
    add("NOPI",  2'b00, 6'b110010, 2, E_FETCH, E_DEC, E_ZERO, E_ZERO, E_ZERO);
    add("NONE",  2'b00, 6'b000000, 2, E_FETCH, E_DEC, E_ZERO, E_ZERO, E_ZERO);
    add("IMM0",  2'b00, 6'b100000, 4, E_FETCH, E_DEC, E_EXI, E_AWB, E_ZERO);
    add("ILL",   2'b11, 6'b000000, 3, E_FETCH, E_DEC, E_ILL, E_ZERO, E_ZERO);
    add("ILL2",  2'b11, 6'b111111, 3, E_FETCH, E_DEC, E_ILL, E_ZERO, E_ZERO);
    add("SUB",   2'b00, 6'b000100, 4, E_FETCH, E_DEC, E_EXR, E_AWB, E_ZERO);

    repeat (2) @(negedge clk);
    chk("reset_outputs", outs, E_ZERO);
    reset = 1'b0;
    #1;
    chk("first_fetch", outs, E_FETCH);

    foreach (vecs[i]) begin
      Op    = vecs[i].op;
      Funct = vecs[i].funct;
      for (int c = 0; c < vecs[i].len; c++) begin
        chk($sformatf("%s_c%0d", vecs[i].name, c + 1), outs, vecs[i].exp[c]);
        @(negedge clk);
      end
      chk($sformatf("%s_return", vecs[i].name), outs, E_FETCH);
    end

    // reset asserted while in MEMRD of a load
    Op    = 2'b01;
    Funct = 6'b011001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_memrd", outs, E_MRD);
    mon    = 1'b1;
    reset  = 1'b1;
    #1;
    chk("mid_reset_mask", outs, E_ZERO);
    @(negedge clk);
    chk("mid_reset_hold", outs, E_ZERO);
    reset = 1'b0;
    #1;
    chk("mid_release_fetch", outs, E_FETCH);
    @(negedge clk);
    chk("mid_release_dec", outs, E_DEC);
    Op    = 2'b00;
    Funct = 6'b000000;
    @(negedge clk);
    mon = 1'b0;
    chk("mid_no_write", {14'b0, saw_wr}, E_ZERO);
    chk("mid_back_fetch", outs, E_FETCH);

    // reset during BRANCHL suppresses the link write
    Op    = 2'b10;
    Funct = 6'b010000;
    @(negedge clk);
    @(negedge clk);
    chk("brl_before_reset", outs, E_BRL);
    reset = 1'b1;
    #1;
    chk("brl_reset_mask", outs, E_ZERO);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("brl_release_fetch", outs, E_FETCH);
    @(negedge clk);
    chk("brl_release_dec", outs, E_DEC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, which is synchronous and active-high.
REQ-003 The block SHALL have port Op, input, 2, the instruction class from the instruction register (00 DP, 01 MEM, 10 BR, 11 unimplemented).
REQ-004 The block SHALL have port Funct, input, 6, instr[25:20]: I-bit, cmd, S or L bit.
REQ-005 The block SHALL have port IRWrite, output, 1, the instruction register load enable.
REQ-006 The block SHALL have port NextPC, output, 1, the PC update request.
REQ-007 The block SHALL have port AdrSrc, output, 1, the memory address select (0 PC, 1 ALU result).
REQ-008 The block SHALL have ports ALUSrcA and ALUSrcB, output, 2 each, the ALU operand selects.
REQ-009 The block SHALL have port ResultSrc, output, 2, the result select (00 ALUOut, 01 Data, 10 ALUResult).
REQ-010 The block SHALL have ports RegW, MemW, Branch, BrL and ALUOp, output, 1 each.
REQ-011 The block SHALL have port Illegal, output, 1, a one-cycle flag for an unimplemented opcode.

Function
REQ-012 The block SHALL be a Moore FSM; every output SHALL be a function of the current state only, and any output not listed for a state SHALL be 0.
REQ-013 The states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, BRANCHL and ILLEGAL.
REQ-014 FETCH SHALL drive AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1 and NextPC=1, then go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10 and ResultSrc=10 (PC+8 read).
REQ-016 From DECODE the next state SHALL be:
  - Op=01: MEMADR.
  - Op=00 with Funct[4:0]=10010 (NOP): FETCH.
  - Op=00 with Funct[5]=1: EXECUTEI.
  - Op=00 with Funct[4:0]=00000: FETCH.
  - Any other Op=00: EXECUTER.
  - Op=10 with Funct[4]=1: BRANCHL.
  - Op=10 with Funct[4]=0: BRANCH.
  - Op=11: ILLEGAL.
REQ-017 MEMADR SHALL drive ALUSrcA=00 and ALUSrcB=01, then go to MEMRD if Funct[0]=1, else MEMWR.
REQ-018 MEMRD SHALL drive AdrSrc=1 and ResultSrc=00, then go to MEMWB.
REQ-019 MEMWB SHALL drive ResultSrc=01 and RegW=1, then go to FETCH.
REQ-020 MEMWR SHALL drive AdrSrc=1, ResultSrc=00 and MemW=1, then go to FETCH.
REQ-021 EXECUTER SHALL drive ALUSrcA=00, ALUSrcB=00 and ALUOp=1, then go to ALUWB.
REQ-022 EXECUTEI SHALL drive ALUSrcA=00, ALUSrcB=01 and ALUOp=1, then go to ALUWB.
REQ-023 ALUWB SHALL drive ResultSrc=00 and RegW=1, then go to FETCH.
REQ-024 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=01, ResultSrc=10 and Branch=1, then go to FETCH.
REQ-025 BRANCHL SHALL drive the BRANCH outputs plus BrL=1 and RegW=1 (link write), then go to FETCH.
REQ-026 ILLEGAL SHALL drive Illegal=1 for exactly one cycle, with no register or memory writes, then go to FETCH.
REQ-027 Instruction latency in cycles SHALL be:
  - LDR: 5.
  - STR: 4.
  - DP: 4.
  - B/BL: 3.
  - NOP, do-nothing and illegal: 2 (illegal 3, including ILLEGAL).
REQ-028 In every state, at most one of RegW and MemW SHALL be asserted.
REQ-029 In every state, IRWrite SHALL be asserted only in FETCH.

Reset
REQ-030 While reset=1 at a clk edge, the next state SHALL be FETCH regardless of the current state, including mid-instruction.
REQ-031 While reset=1, IRWrite, NextPC, RegW, MemW, Branch, BrL, ALUOp and Illegal SHALL be forced to 0, and all selects SHALL be 00/0.
REQ-032 The first cycle after reset deasserts SHALL be FETCH with its normal outputs.

Structure
REQ-033 The state enum (statetype_t, 4-bit) and the select encodings (ADR_PC, ADR_ALU, SRCA_*, SRCB_*, RES_*) SHALL reside in shared package ctrl_pkg.
REQ-034 The state register and next-state logic SHALL be in one always_ff/always_comb pair.
REQ-035 Output decode SHALL be in-module; no sub-module is required.
REQ-036 Flag/condition logic and ALU function decode SHALL remain outside this block.

Verification
REQ-037 The bench SHALL cover LDR: reset, then Op=01, Funct=011001 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegW=1 only in cycle 5, ResultSrc=01.
REQ-038 The bench SHALL cover STR: Op=01, Funct=011000 -> MemW=1 only in cycle 4, AdrSrc=1; next cycle IRWrite=1.
REQ-039 The bench SHALL cover ADD: immediate Op=00, Funct=101000 -> EXECUTEI with ALUSrcB=01, ALUOp=1, then ALUWB with RegW=1; register form Funct=001000 -> EXECUTER with ALUSrcB=00.
REQ-040 The bench SHALL cover branches: BL Op=10, Funct=010000 -> cycle 3 Branch=1, BrL=1, RegW=1; B Funct=000000 -> Branch=1, BrL=0, RegW=0.
REQ-041 The bench SHALL cover NOP and illegal: NOP Op=00, Funct=010010 -> FETCH after DECODE, no RegW; Op=11 -> Illegal=1 for one cycle, then FETCH.
REQ-042 The bench SHALL cover reset mid-instruction: reset=1 during MEMRD -> next cycle all enables 0; after release, FETCH with IRWrite=1, and MemW/RegW never asserted.
